pipe_hazard_ctrl: RTL and testbench

Hazard and memory-wait controller for the 5-stage MIPS pipeline. Generates stall/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB latches, and the bypass selects for the D and E stages. It also sequences the variable-latency data-memory access of the M stage over a req/ack handshake, with a timeout.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, bypass and data-memory wait controller for the 5-stage MIPS pipeline.
// Optional stall-cycle counter output enabled by defining STALL_COUNT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeRegE,
  input  logic [4:0] writeRegM,
  input  logic [4:0] writeRegW,
  input  logic       regWriteE,
  input  logic       regWriteM,
  input  logic       regWriteW,
  input  logic       memtoRegE,
  input  logic       memtoRegM,
  input  logic       branchD,
  input  logic       memOpM,
  input  logic       memAck,
  output logic       memReq,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushE,
  output logic       flushW,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       memErr
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] stallCnt
`endif
);

  typedef enum logic {StRun, StMemWait} state_t;

  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_state_d;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_d;
  logic       r_mem_err;
  logic       w_mem_err_d;
  logic       w_mem_req;
  logic       w_timeout_hit;
  logic       w_mem_stall;
  logic       w_lw_stall;
  logic       w_br_stall;

  // r_wait_cnt counts stalled cycles of the current access, the RUN cycle included.
  assign w_mem_req     = memOpM & ~clr;
  assign w_timeout_hit = w_mem_req & ~memAck & (r_wait_cnt == TimeoutLast);
  assign w_mem_stall   = w_mem_req & ~memAck & ~w_timeout_hit;

  assign w_lw_stall = memtoRegE & ((rtE == rsD) | (rtE == rtD));
  assign w_br_stall = branchD &
                      ((regWriteE & ((writeRegE == rsD) | (writeRegE == rtD))) |
                       (memtoRegM & ((writeRegM == rsD) | (writeRegM == rtD))));

  function automatic logic [1:0] fwd_sel_e(input logic [4:0] r_x, input logic rw_m,
                                           input logic [4:0] wr_m, input logic rw_w,
                                           input logic [4:0] wr_w);
    if ((r_x != 5'd0) && rw_m && (r_x == wr_m)) begin
      return 2'b10;
    end else if ((r_x != 5'd0) && rw_w && (r_x == wr_w)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    w_mem_err_d  = r_mem_err | w_timeout_hit;
    unique case (r_state)
      StRun: begin
        if (w_mem_stall) begin
          w_state_d    = StMemWait;
          w_wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        if (~w_mem_stall) begin
          w_state_d    = StRun;
          w_wait_cnt_d = 8'd0;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 8'd1;
        end
      end
      default: begin
        w_state_d    = StRun;
        w_wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= StRun;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wait_cnt <= w_wait_cnt_d;
      r_mem_err  <= w_mem_err_d;
    end
  end

  always_comb begin
    memReq    = w_mem_req;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    stallM    = 1'b0;
    flushE    = 1'b0;
    flushW    = 1'b0;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (!clr) begin
      forwardAD = (rsD != 5'd0) & regWriteM & (rsD == writeRegM);
      forwardBD = (rtD != 5'd0) & regWriteM & (rtD == writeRegM);
      forwardAE = fwd_sel_e(rsE, regWriteM, writeRegM, regWriteW, writeRegW);
      forwardBE = fwd_sel_e(rtE, regWriteM, writeRegM, regWriteW, writeRegW);
      if (w_mem_stall) begin
        // Flush MEM/WB so the held M instruction does not write back twice.
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        stallM = 1'b1;
        flushW = 1'b1;
      end else if (w_lw_stall | w_br_stall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  assign memErr = r_mem_err;

`ifdef STALL_COUNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
    end else if (stallF && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stallCnt = r_stall_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed steps followed by random cycles
// checked against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned TO   = 4;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       regWriteE, regWriteM, regWriteW, memtoRegE, memtoRegM;
  logic       branchD, memOpM, memAck;
  logic       memReq, stallF, stallD, stallE, stallM, flushE, flushW;
  logic       forwardAD, forwardBD, memErr;
  logic [1:0] forwardAE, forwardBE;
`ifdef STALL_COUNT_EN
  logic [CW-1:0] stallCnt;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE), .writeRegM(writeRegM), .writeRegW(writeRegW),
    .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
    .memtoRegE(memtoRegE), .memtoRegM(memtoRegM), .branchD(branchD),
    .memOpM(memOpM), .memAck(memAck), .memReq(memReq),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW), .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .memErr(memErr)
`ifdef STALL_COUNT_EN
    , .stallCnt(stallCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  // Reference model: stalled-cycle count of the current access, sticky error, stall count.
  int m_wait = 0;
  bit m_err = 1'b0;
  int m_scnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] m_fwd_e(input logic [4:0] r);
    if (r != 0 && regWriteM && r == writeRegM) return 2'd2;
    if (r != 0 && regWriteW && r == writeRegW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit m_mem_stall();
    return memOpM && !memAck && (m_wait != TO - 1);
  endfunction

  function automatic logic [5:0] m_stall_vec();
    bit lw, br;
    lw = memtoRegE && (rtE == rsD || rtE == rtD);
    br = branchD && ((regWriteE && (writeRegE == rsD || writeRegE == rtD)) ||
                     (memtoRegM && (writeRegM == rsD || writeRegM == rtD)));
    // {stallF, stallD, stallE, stallM, flushE, flushW}
    if (m_mem_stall()) return 6'b111101;
    if (lw || br) return 6'b110010;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] m_fwd_vec();
    logic ad, bd;
    ad = rsD != 0 && regWriteM && rsD == writeRegM;
    bd = rtD != 0 && regWriteM && rtD == writeRegM;
    return {ad, bd, m_fwd_e(rsE), m_fwd_e(rtE)};
  endfunction

  // Inputs are already applied; check the cycle, then advance model and clock.
  task automatic step(input string tag);
    logic [5:0] sv;
    #2;
    sv = m_stall_vec();
    chk({tag, ".stall"}, 32'({stallF, stallD, stallE, stallM, flushE, flushW}), 32'(sv));
    chk({tag, ".fwd"}, 32'({forwardAD, forwardBD, forwardAE, forwardBE}), 32'(m_fwd_vec()));
    chk({tag, ".memReq"}, 32'(memReq), 32'(memOpM));
    chk({tag, ".memErr"}, 32'(memErr), 32'(m_err));
`ifdef STALL_COUNT_EN
    chk({tag, ".stallCnt"}, 32'(stallCnt), 32'(m_scnt));
`endif
    @(posedge clk);
    if (memOpM && !memAck) begin
      if (m_wait == TO - 1) begin
        m_err  = 1'b1;
        m_wait = 0;
      end else begin
        m_wait++;
      end
    end else begin
      m_wait = 0;
    end
    if (sv[5] && m_scnt < CMAX) m_scnt++;
    #1;
  endtask

  task automatic idle_inputs();
    {rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW} = '0;
    {regWriteE, regWriteM, regWriteW, memtoRegE, memtoRegM, branchD, memOpM, memAck} = '0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    #1;
    clr = 1'b0;
    m_wait = 0;
    m_err  = 1'b0;
    m_scnt = 0;
  endtask

  int n_req;
  int n_stl;

  initial begin
    idle_inputs();
    clr = 1'b1;
    // Hazard-provoking inputs while in reset: outputs must stay low.
    memOpM = 1'b1; memtoRegE = 1'b1; regWriteM = 1'b1; rsE = 5'd3; writeRegM = 5'd3;
    #12;
    chk("rst.stall", 32'({stallF, stallD, stallE, stallM, flushE, flushW}), 32'd0);
    chk("rst.fwdAE", 32'(forwardAE), 32'd0);
    chk("rst.memReq", 32'(memReq), 32'd0);
    chk("rst.memErr", 32'(memErr), 32'd0);
    idle_inputs();
    clr = 1'b0;
    @(posedge clk); #1;

    // ALU chain forwarding, M over W
    regWriteM = 1; writeRegM = 8; rsE = 8; rtE = 9; regWriteW = 1; writeRegW = 9;
    #2;
    chk("alu.fwdAE", 32'(forwardAE), 32'd2);
    chk("alu.fwdBE", 32'(forwardBE), 32'd1);
    step("alu");
    rsE = 0;
    #2;
    chk("alu0.fwdAE", 32'(forwardAE), 32'd0);
    step("alu0");
    writeRegW = 8; rtE = 8;
    step("alu_prio");

    // Load-use
    idle_inputs();
    memtoRegE = 1; rtE = 5; rsD = 5;
    #2;
    chk("lw.stallF", 32'({stallF, stallD, flushE}), 32'h7);
    step("lw");
    memtoRegE = 0;
    step("lw_clear");

    // Branch hazard, then bypass from M
    idle_inputs();
    branchD = 1; regWriteE = 1; writeRegE = 3; rtD = 3;
    step("br");
    regWriteE = 0; writeRegE = 0; regWriteM = 1; writeRegM = 3;
    #2;
    chk("br2.fwdBD", 32'({forwardBD, stallF}), 32'h2);
    step("br2");

    // Memory wait: ack after three stalled cycles
    idle_inputs();
    memOpM = 1;
    n_req = 0;
    n_stl = 0;
    for (int i = 0; i < 4; i++) begin
      memAck = (i == 3);
      #1;
      n_req += int'(memReq);
      n_stl += int'(stallM && flushW);
      #1;
      step("mw");
    end
    chk("mw.req_cycles", 32'(n_req), 32'd4);
    chk("mw.stall_cycles", 32'(n_stl), 32'd3);
    memOpM = 1; memAck = 1;
    step("mw_zero");
    memOpM = 0; memAck = 0;
    step("mw_after");

    // Timeout: three stalled cycles, the fourth aborts
    memOpM = 1;
    for (int i = 0; i < TO; i++) step("to");
    memOpM = 0;
    #2;
    chk("to.memErr", 32'(memErr), 32'd1);
    step("to_after");
    step("to_sticky");

    // Async clear during a wait
    memOpM = 1;
    step("clrw");
    step("clrw");
    clr = 1'b1;
    #1;
    chk("clrw.memReq", 32'(memReq), 32'd0);
    chk("clrw.stallF", 32'(stallF), 32'd0);
    chk("clrw.memErr", 32'(memErr), 32'd0);
    clr = 1'b0;
    memOpM = 0;
    m_wait = 0; m_err = 1'b0; m_scnt = 0;
    step("clrw_after");

`ifdef STALL_COUNT_EN
    // Five load-use stall cycles saturate a 2-bit counter
    pulse_clr();
    memtoRegE = 1; rtE = 5; rsD = 5;
    for (int i = 0; i < 5; i++) step("sat");
    memtoRegE = 0;
    #2;
    chk("sat.stallCnt", 32'(stallCnt), 32'(CMAX));
    step("sat_hold");
`endif

    // Random cycles against the model
    pulse_clr();
    for (int i = 0; i < 400; i++) begin
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeRegE = 5'($urandom_range(0, 3)); writeRegM = 5'($urandom_range(0, 3));
      writeRegW = 5'($urandom_range(0, 3));
      regWriteE = 1'($urandom_range(0, 1)); regWriteM = 1'($urandom_range(0, 1));
      regWriteW = 1'($urandom_range(0, 1)); memtoRegE = ($urandom_range(0, 3) == 0);
      memtoRegM = ($urandom_range(0, 3) == 0); branchD = ($urandom_range(0, 2) == 0);
      memOpM = ($urandom_range(0, 9) < 6); memAck = ($urandom_range(0, 9) < 2);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
